// File: rtl/hz_pkg.sv
// Shared defaults and forwarding-select encoding for the hazard scoreboard.
package hz_pkg;

  localparam int unsigned NREG_DEF    = 16;
  localparam int unsigned NWP_DEF     = 2;
  localparam int unsigned MAX_LAT_DEF = 4;

  // Forward select: 0 reads the register file, k bypasses from write port k-1.
  localparam int unsigned FWD_RF        = 0;
  localparam int unsigned FWD_PORT_BASE = 1;

  localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/execute <-> scoreboard signal bundle.
interface hazard_scoreboard_if #(
  parameter int unsigned NREG    = hz_pkg::NREG_DEF,
  parameter int unsigned NWP     = hz_pkg::NWP_DEF,
  parameter int unsigned MAX_LAT = hz_pkg::MAX_LAT_DEF
) ();

  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned LW = $clog2(MAX_LAT + 1);
  localparam int unsigned FW = $clog2(NWP + 1);

  logic                  issue_valid;
  logic [1:0]            src_en;
  logic [RW-1:0]         src1;
  logic [RW-1:0]         src2;
  logic [NWP-1:0]        dst_we;
  logic [NWP*RW-1:0]     dst;
  logic [NWP*LW-1:0]     dst_lat;
  logic                  branch_taken_e;
  logic                  stall_f;
  logic                  stall_d;
  logic                  flush_d;
  logic                  flush_e;
  logic [FW-1:0]         fwd1;
  logic [FW-1:0]         fwd2;
  logic [hz_pkg::STALL_CNT_W-1:0] stall_count;

  modport master (
    output issue_valid, src_en, src1, src2, dst_we, dst, dst_lat, branch_taken_e,
    input  stall_f, stall_d, flush_d, flush_e, fwd1, fwd2, stall_count
  );

  modport slave (
    input  issue_valid, src_en, src1, src2, dst_we, dst, dst_lat, branch_taken_e,
    output stall_f, stall_d, flush_d, flush_e, fwd1, fwd2, stall_count
  );

endinterface

// File: rtl/hz_entry.sv
// One scoreboard slot: remaining-latency counter plus producing write port.
module hz_entry #(
  parameter int unsigned LW = 3,
  parameter int unsigned PW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [LW-1:0] load_cnt,
  input  logic [PW-1:0] load_port,
  input  logic          restore,
  input  logic [LW-1:0] restore_cnt,
  input  logic [PW-1:0] restore_port,
  output logic [LW-1:0] cnt,
  output logic [PW-1:0] port
);

  // Restore (branch undo) and load (issue) never coincide; either replaces the decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      port <= '0;
    end else if (restore) begin
      cnt  <= restore_cnt;
      port <= restore_port;
    end else if (load) begin
      cnt  <= load_cnt;
      port <= load_port;
    end else if (cnt != '0) begin
      cnt  <= cnt - LW'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: RAW/WAW stall, bypass select, and one-deep branch undo.
module hazard_scoreboard
  import hz_pkg::*;
#(
  parameter int unsigned NREG    = NREG_DEF,
  parameter int unsigned NWP     = NWP_DEF,
  parameter int unsigned MAX_LAT = MAX_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  hazard_scoreboard_if.slave bus
);

  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned LW = $clog2(MAX_LAT + 1);
  localparam int unsigned PW = (NWP > 1) ? $clog2(NWP) : 1;
  localparam int unsigned FW = $clog2(NWP + 1);
  localparam int unsigned SW = STALL_CNT_W;
  localparam logic [LW-1:0] LAT_MAX = LW'(MAX_LAT);

  logic [LW-1:0] cnt       [NREG];
  logic [PW-1:0] port      [NREG];
  logic [NREG-1:0] ld;
  logic [NREG-1:0] rs;
  logic [LW-1:0] ld_cnt    [NREG];
  logic [PW-1:0] ld_port   [NREG];
  logic [LW-1:0] rs_cnt    [NREG];
  logic [PW-1:0] rs_port   [NREG];

  logic [RW-1:0] dst_idx   [NWP];
  logic [LW-1:0] lat_eff   [NWP];

  logic [NWP-1:0] undo_v;
  logic [RW-1:0]  undo_dst  [NWP];
  logic [LW-1:0]  undo_cnt  [NWP];
  logic [PW-1:0]  undo_port [NWP];

  logic          raw;
  logic          waw;
  logic          stall;
  logic          issued;
  logic [SW-1:0] stall_cnt_q;

  // Split packed destination fields; latency 0 or above MAX_LAT means MAX_LAT.
  always_comb begin
    for (int p = 0; p < NWP; p++) begin
      dst_idx[p] = bus.dst[p*RW +: RW];
      lat_eff[p] = bus.dst_lat[p*LW +: LW];
      if (lat_eff[p] == '0 || lat_eff[p] > LAT_MAX) lat_eff[p] = LAT_MAX;
    end
  end

  // RAW: a source still more than one cycle out; WAW: older write would land after ours.
  always_comb begin
    raw = (bus.src_en[0] && (cnt[bus.src1] > LW'(1))) ||
          (bus.src_en[1] && (cnt[bus.src2] > LW'(1)));
    waw = 1'b0;
    for (int p = 0; p < NWP; p++) begin
      if (bus.dst_we[p] && (cnt[dst_idx[p]] > lat_eff[p])) waw = 1'b1;
    end
  end

  assign stall  = bus.issue_valid & (raw | waw) & ~bus.branch_taken_e & ~reset;
  assign issued = bus.issue_valid & ~stall & ~bus.branch_taken_e & ~reset;

  // Pipeline control and bypass selects.
  always_comb begin
    bus.stall_f = stall;
    bus.stall_d = stall;
    bus.flush_d = bus.branch_taken_e;
    bus.flush_e = bus.branch_taken_e | stall;
    bus.fwd1    = FW'(FWD_RF);
    bus.fwd2    = FW'(FWD_RF);
    if (bus.src_en[0] && cnt[bus.src1] == LW'(1))
      bus.fwd1 = FW'(port[bus.src1]) + FW'(FWD_PORT_BASE);
    if (bus.src_en[1] && cnt[bus.src2] == LW'(1))
      bus.fwd2 = FW'(port[bus.src2]) + FW'(FWD_PORT_BASE);
  end

  // Per-slot load/restore decode; later ports overwrite earlier ones on duplicates.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      ld[r]      = 1'b0;
      ld_cnt[r]  = '0;
      ld_port[r] = '0;
      rs[r]      = 1'b0;
      rs_cnt[r]  = '0;
      rs_port[r] = '0;
      for (int p = 0; p < NWP; p++) begin
        if (issued && bus.dst_we[p] && dst_idx[p] == RW'(r)) begin
          ld[r]      = 1'b1;
          ld_cnt[r]  = lat_eff[p];
          ld_port[r] = PW'(p);
        end
        if (bus.branch_taken_e && undo_v[p] && undo_dst[p] == RW'(r)) begin
          rs[r]      = 1'b1;
          rs_cnt[r]  = undo_cnt[p];
          rs_port[r] = undo_port[p];
        end
      end
    end
  end

  // Undo record: pre-issue state of each written slot, valid for exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      undo_v <= '0;
      for (int p = 0; p < NWP; p++) begin
        undo_dst[p]  <= '0;
        undo_cnt[p]  <= '0;
        undo_port[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NWP; p++) begin
        undo_v[p]    <= issued & bus.dst_we[p];
        undo_dst[p]  <= dst_idx[p];
        undo_cnt[p]  <= cnt[dst_idx[p]];
        undo_port[p] <= port[dst_idx[p]];
      end
    end
  end

  // Saturating count of decode-stall cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != {SW{1'b1}})
      stall_cnt_q <= stall_cnt_q + SW'(1);
  end

  assign bus.stall_count = stall_cnt_q;

  for (genvar r = 0; r < NREG; r++) begin : g_entry
    hz_entry #(.LW(LW), .PW(PW)) u_entry (
      .clk          (clk),
      .reset        (reset),
      .load         (ld[r]),
      .load_cnt     (ld_cnt[r]),
      .load_port    (ld_port[r]),
      .restore      (rs[r]),
      .restore_cnt  (rs_cnt[r]),
      .restore_port (rs_port[r]),
      .cnt          (cnt[r]),
      .port         (port[r])
    );
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed bench for hazard_scoreboard against a behavioural model.
module tb_hazard_scoreboard;
  import hz_pkg::*;

  localparam int unsigned NREG = 16;
  localparam int unsigned NWP = 2;
  localparam int unsigned MAX_LAT = 4;
  localparam int unsigned RW = 4;
  localparam int unsigned LW = 3;
  localparam int SAT = 65535;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(NREG), .NWP(NWP), .MAX_LAT(MAX_LAT)) bus ();

  hazard_scoreboard #(.NREG(NREG), .NWP(NWP), .MAX_LAT(MAX_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: remaining cycles and producing port per register, plus last-issue undo list.
  typedef struct { int dst; int cnt; int port; } undo_t;
  int    m_cnt [NREG];
  int    m_port[NREG];
  undo_t m_undo[$];
  int    m_stalls = 0;

  logic        obs_stall, obs_fd, obs_fe;
  logic [1:0]  obs_f1, obs_f2;
  logic [15:0] obs_sc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int eff_lat(input int l);
    return (l == 0 || l > int'(MAX_LAT)) ? int'(MAX_LAT) : l;
  endfunction

  function automatic int sat_count(input int n);
    return (n > SAT) ? SAT : n;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < int'(NREG); r++) begin
      m_cnt[r]  = 0;
      m_port[r] = 0;
    end
    m_undo.delete();
    m_stalls = 0;
  endtask

  task automatic drive_idle();
    bus.issue_valid    = 1'b0;
    bus.src_en         = 2'b00;
    bus.src1           = '0;
    bus.src2           = '0;
    bus.dst_we         = '0;
    bus.dst            = '0;
    bus.dst_lat        = '0;
    bus.branch_taken_e = 1'b0;
  endtask

  // One clock cycle: drive, compare against model, clock, advance model.
  task automatic step(input bit iv, input bit [1:0] se, input int s1, input int s2,
                      input bit [1:0] we, input int d0, input int d1,
                      input int l0, input int l1, input bit br, input bit chk_en);
    int ds[2];
    int ls[2];
    int nc[NREG];
    int np[NREG];
    undo_t nu[$];
    bit raw, waw, stall;
    int f1, f2;
    @(negedge clk);
    bus.issue_valid    = iv;
    bus.src_en         = se;
    bus.src1           = RW'(s1);
    bus.src2           = RW'(s2);
    bus.dst_we         = we;
    bus.dst            = {RW'(d1), RW'(d0)};
    bus.dst_lat        = {LW'(l1), LW'(l0)};
    bus.branch_taken_e = br;
    ds[0] = d0; ds[1] = d1;
    ls[0] = eff_lat(l0); ls[1] = eff_lat(l1);
    raw = (se[0] && m_cnt[s1] > 1) || (se[1] && m_cnt[s2] > 1);
    waw = 1'b0;
    for (int p = 0; p < 2; p++) if (we[p] && m_cnt[ds[p]] > ls[p]) waw = 1'b1;
    stall = iv && (raw || waw) && !br;
    f1 = (se[0] && m_cnt[s1] == 1) ? m_port[s1] + 1 : int'(FWD_RF);
    f2 = (se[1] && m_cnt[s2] == 1) ? m_port[s2] + 1 : int'(FWD_RF);
    #1;
    obs_stall = bus.stall_d;
    obs_fd    = bus.flush_d;
    obs_fe    = bus.flush_e;
    obs_f1    = bus.fwd1;
    obs_f2    = bus.fwd2;
    obs_sc    = bus.stall_count;
    if (chk_en) begin
      check("stall_f", 32'(bus.stall_f), 32'(stall));
      check("stall_d", 32'(bus.stall_d), 32'(stall));
      check("flush_d", 32'(bus.flush_d), 32'(br));
      check("flush_e", 32'(bus.flush_e), 32'(br || stall));
      check("fwd1", 32'(bus.fwd1), 32'(f1));
      check("fwd2", 32'(bus.fwd2), 32'(f2));
      check("stall_count", 32'(bus.stall_count), 32'(sat_count(m_stalls)));
    end
    @(posedge clk);
    for (int r = 0; r < int'(NREG); r++) begin
      nc[r] = (m_cnt[r] > 0) ? m_cnt[r] - 1 : 0;
      np[r] = m_port[r];
    end
    if (br) foreach (m_undo[i]) begin
      nc[m_undo[i].dst] = m_undo[i].cnt;
      np[m_undo[i].dst] = m_undo[i].port;
    end
    if (iv && !stall && !br) begin
      for (int p = 0; p < 2; p++) if (we[p]) begin
        nu.push_back('{ds[p], m_cnt[ds[p]], m_port[ds[p]]});
        nc[ds[p]] = ls[p];
        np[ds[p]] = p;
      end
    end
    if (stall) m_stalls++;
    m_cnt  = nc;
    m_port = np;
    m_undo = nu;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    model_clear();
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_stall_d", 32'(bus.stall_d), 32'd0);
    check("rst_flush_e", 32'(bus.flush_e), 32'd0);
    check("rst_fwd1", 32'(bus.fwd1), 32'd0);
    check("rst_stall_count", 32'(bus.stall_count), 32'd0);
    reset = 1'b0;

    // Load-use: r5 latency 3, reader stalls two cycles then bypasses from port A.
    step(1, 2'b00, 0, 0, 2'b01, 5, 0, 3, 0, 0, 1);
    step(1, 2'b01, 5, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    check("lu_stall1", 32'(obs_stall), 32'd1);
    step(1, 2'b01, 5, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    check("lu_stall2", 32'(obs_stall), 32'd1);
    step(1, 2'b01, 5, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    check("lu_release", 32'(obs_stall), 32'd0);
    check("lu_fwd1", 32'(obs_f1), 32'd1);
    idle(1);
    check("lu_stall_count", 32'(obs_sc), 32'd2);

    // Single-cycle producer: no stall, bypass from port A.
    idle(4);
    step(1, 2'b00, 0, 0, 2'b01, 3, 0, 1, 0, 0, 1);
    step(1, 2'b01, 3, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    check("alu_stall", 32'(obs_stall), 32'd0);
    check("alu_fwd1", 32'(obs_f1), 32'd1);

    // Both ports write r2: port B wins.
    idle(4);
    step(1, 2'b00, 0, 0, 2'b11, 2, 2, 2, 1, 0, 1);
    step(1, 2'b10, 0, 2, 2'b00, 0, 0, 0, 0, 0, 1);
    check("dup_fwd2", 32'(obs_f2), 32'd2);
    check("dup_stall", 32'(obs_stall), 32'd0);

    // Taken branch undoes r4 latency-3 write.
    idle(4);
    step(1, 2'b00, 0, 0, 2'b01, 4, 0, 3, 0, 0, 1);
    step(1, 2'b01, 4, 0, 2'b00, 0, 0, 0, 0, 1, 1);
    check("br_flush_d", 32'(obs_fd), 32'd1);
    check("br_flush_e", 32'(obs_fe), 32'd1);
    check("br_no_stall", 32'(obs_stall), 32'd0);
    step(1, 2'b01, 4, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    check("br_reader_stall", 32'(obs_stall), 32'd0);
    check("br_reader_fwd", 32'(obs_f1), 32'd0);

    // Random traffic over a small register window to force hazards.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(3, 0) != 0, 2'($urandom), int'($urandom_range(5, 0)),
           int'($urandom_range(5, 0)), 2'($urandom), int'($urandom_range(5, 0)),
           int'($urandom_range(5, 0)), int'($urandom_range(7, 0)),
           int'($urandom_range(7, 0)), $urandom_range(9, 0) == 0, 1);
    end

    // Reset asserted while stalled releases stall in the same cycle.
    idle(4);
    step(1, 2'b00, 0, 0, 2'b01, 5, 0, 3, 0, 0, 1);
    @(negedge clk);
    bus.issue_valid = 1'b1;
    bus.src_en      = 2'b01;
    bus.src1        = RW'(5);
    #1;
    check("rst_mid_pre", 32'(bus.stall_d), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_stall_f", 32'(bus.stall_f), 32'd0);
    check("rst_mid_stall_d", 32'(bus.stall_d), 32'd0);
    check("rst_mid_count", 32'(bus.stall_count), 32'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    reset = 1'b0;

    // Saturation: r1 reload each issue gives three stall cycles out of four.
    for (int i = 0; i < 21850; i++) begin
      for (int k = 0; k < 4; k++) step(1, 2'b01, 1, 0, 2'b01, 1, 0, 4, 0, 0, 0);
    end
    step(1, 2'b01, 1, 0, 2'b01, 1, 0, 4, 0, 0, 1);
    check("sat_value", 32'(obs_sc), 32'hFFFF);
    step(1, 2'b01, 1, 0, 2'b01, 1, 0, 4, 0, 0, 1);
    check("sat_hold_stall", 32'(obs_stall), 32'd1);
    step(1, 2'b01, 1, 0, 2'b01, 1, 0, 4, 0, 0, 1);
    check("sat_hold", 32'(obs_sc), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
